// File: rtl/canbus_io_cycle_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : canbus_io_cycle_controller                                  |
// | Purpose  : Bus-cycle sequencer between the 68k bus and the off-chip    |
// |            CAN controller. Turns a 68k access in the CAN window into   |
// |            timed chip-select / read / write strobes and a dtack, with  |
// |            programmable setup, strobe and recovery wait states.        |
// | Ports    :                                                             |
// |   Clock          in   system clock, rising edge                        |
// |   Reset_L        in   asynchronous active-low reset                    |
// |   AS_L           in   68k address strobe                               |
// |   UDS_L, LDS_L   in   68k upper / lower data strobes                   |
// |   RW             in   68k read/write (1 = read)                        |
// |   CanBusSelect_H in   address-decoder select for the CAN window        |
// |   CanBusCS_L     out  CAN chip select                                  |
// |   CanBusRD_L     out  CAN read strobe                                  |
// |   CanBusWR_L     out  CAN write strobe                                 |
// |   CanBusDtack_L  out  dtack towards the dtack generator                |
// |   Busy_H         out  high whenever the sequencer is not idle          |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module canbus_io_cycle_controller #(
  parameter int unsigned SETUP_CLKS    = 1,  // 0..15
  parameter int unsigned STROBE_CLKS   = 3,  // 0..15
  parameter int unsigned RECOVERY_CLKS = 2   // 0..15
) (
  input  logic Clock,
  input  logic Reset_L,
  input  logic AS_L,
  input  logic UDS_L,
  input  logic LDS_L,
  input  logic RW,
  input  logic CanBusSelect_H,
  output logic CanBusCS_L,
  output logic CanBusRD_L,
  output logic CanBusWR_L,
  output logic CanBusDtack_L,
  output logic Busy_H
);

  // Wait-state reload values, trimmed to the 4-bit counter.
  localparam logic [3:0] SETUP_LOAD    = 4'(SETUP_CLKS);
  localparam logic [3:0] STROBE_LOAD   = 4'(STROBE_CLKS);
  localparam logic [3:0] RECOVERY_LOAD = 4'(RECOVERY_CLKS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_ACK     = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [3:0] count;
  logic [3:0] next_count;
  logic       rw_latched;
  logic       next_rw;
  logic       ds_active;

  logic       next_cs_l;
  logic       next_rd_l;
  logic       next_wr_l;
  logic       next_dtack_l;
  logic       next_busy;

  assign ds_active = ~UDS_L | ~LDS_L;

  // State, counter and latched direction.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state      <= ST_IDLE;
      count      <= 4'd0;
      rw_latched <= 1'b1;
    end else begin
      state      <= next_state;
      count      <= next_count;
      rw_latched <= next_rw;
    end
  end

  // Next-state logic. Every wait state is loaded on entry and leaves on the
  // edge at which the counter already reads zero, so a state lasts at least
  // its parameter + 1 clocks. AS_L negating always wins over a counter exit,
  // which is what keeps an aborted cycle from ever reaching ACK.
  always_comb begin
    next_state = state;
    next_count = count;
    next_rw    = rw_latched;

    case (state)
      ST_IDLE: begin
        if (!AS_L && CanBusSelect_H) begin
          next_state = ST_SETUP;
          next_count = SETUP_LOAD;
        end
      end

      ST_SETUP: begin
        if (AS_L) begin
          next_state = ST_RECOVER;
          next_count = RECOVERY_LOAD;
        end else if ((count == 4'd0) && ds_active) begin
          // Direction is frozen here; later RW wiggles are ignored.
          next_state = ST_STROBE;
          next_count = STROBE_LOAD;
          next_rw    = RW;
        end else if (count != 4'd0) begin
          // Saturates at zero: SETUP stretches until a data strobe shows up,
          // which covers the late DS of a 68k write.
          next_count = count - 4'd1;
        end
      end

      ST_STROBE: begin
        if (AS_L) begin
          next_state = ST_RECOVER;
          next_count = RECOVERY_LOAD;
        end else if (count == 4'd0) begin
          next_state = ST_ACK;
        end else begin
          next_count = count - 4'd1;
        end
      end

      ST_ACK: begin
        if (AS_L) begin
          next_state = ST_RECOVER;
          next_count = RECOVERY_LOAD;
        end
      end

      ST_RECOVER: begin
        // New selects are ignored here; IDLE picks them up if AS_L is
        // still asserted once recovery has elapsed.
        if (count == 4'd0) begin
          next_state = ST_IDLE;
        end else begin
          next_count = count - 4'd1;
        end
      end

      default: begin
        next_state = ST_IDLE;
        next_count = 4'd0;
      end
    endcase
  end

  // Output decode of the *next* state, so the registered outputs always
  // match the state register with no input-to-output combinational path.
  always_comb begin
    next_cs_l    = 1'b1;
    next_rd_l    = 1'b1;
    next_wr_l    = 1'b1;
    next_dtack_l = 1'b1;
    next_busy    = (next_state != ST_IDLE);

    case (next_state)
      ST_SETUP: begin
        next_cs_l = 1'b0;
      end
      ST_STROBE: begin
        next_cs_l = 1'b0;
        next_rd_l = ~next_rw;
        next_wr_l = next_rw;
      end
      ST_ACK: begin
        next_cs_l    = 1'b0;
        next_rd_l    = ~next_rw;
        next_wr_l    = next_rw;
        next_dtack_l = 1'b0;
      end
      default: begin
        next_cs_l = 1'b1;
      end
    endcase
  end

  // Registered outputs; reset drives every strobe inactive immediately.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      CanBusCS_L    <= 1'b1;
      CanBusRD_L    <= 1'b1;
      CanBusWR_L    <= 1'b1;
      CanBusDtack_L <= 1'b1;
      Busy_H        <= 1'b0;
    end else begin
      CanBusCS_L    <= next_cs_l;
      CanBusRD_L    <= next_rd_l;
      CanBusWR_L    <= next_wr_l;
      CanBusDtack_L <= next_dtack_l;
      Busy_H        <= next_busy;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_canbus_io_cycle_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_canbus_io_cycle_controller                               |
// | Purpose  : Self-checking bench. Two instances (default wait states and |
// |            all-zero wait states) share one stimulus stream and are     |
// |            compared every clock against a timeline reference model.   |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_canbus_io_cycle_controller;

  localparam int DEF_SETUP = 1;
  localparam int DEF_STRB  = 3;
  localparam int DEF_REC   = 2;

  logic Clock = 1'b0;
  logic Reset_L, AS_L, UDS_L, LDS_L, RW, CanBusSelect_H;

  logic cs0, rd0, wr0, dk0, busy0;
  logic cs1, rd1, wr1, dk1, busy1;

  always #5 Clock = ~Clock;

  canbus_io_cycle_controller #(
    .SETUP_CLKS(DEF_SETUP), .STROBE_CLKS(DEF_STRB), .RECOVERY_CLKS(DEF_REC)
  ) dut_def (
    .Clock(Clock), .Reset_L(Reset_L), .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L),
    .RW(RW), .CanBusSelect_H(CanBusSelect_H),
    .CanBusCS_L(cs0), .CanBusRD_L(rd0), .CanBusWR_L(wr0),
    .CanBusDtack_L(dk0), .Busy_H(busy0)
  );

  canbus_io_cycle_controller #(
    .SETUP_CLKS(0), .STROBE_CLKS(0), .RECOVERY_CLKS(0)
  ) dut_zero (
    .Clock(Clock), .Reset_L(Reset_L), .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L),
    .RW(RW), .CanBusSelect_H(CanBusSelect_H),
    .CanBusCS_L(cs1), .CanBusRD_L(rd1), .CanBusWR_L(wr1),
    .CanBusDtack_L(dk1), .Busy_H(busy1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    else
      n_pass++;
  endtask

  // Output bundle: {cs, rd, wr, dtack, busy}
  localparam logic [4:0] QUIET = 5'b11110;

  function automatic logic [4:0] get_out(input int d);
    if (d == 0) return {cs0, rd0, wr0, dk0, busy0};
    return {cs1, rd1, wr1, dk1, busy1};
  endfunction

  // ---------------------------------------------------------------------
  // Reference model: each access is described by the edge numbers at which
  // its milestones happen (start, strobe, dtack, back-to-idle), derived
  // from the wait-state arithmetic rather than a state machine.
  // ---------------------------------------------------------------------
  int p_setup[2] = '{DEF_SETUP, 0};
  int p_strb[2]  = '{DEF_STRB, 0};
  int p_rec[2]   = '{DEF_REC, 0};

  int  edge_n = 0;
  bit  m_active[2];
  int  m_earliest[2];   // first edge a data strobe may launch the strobe
  int  m_strobe_at[2];  // edge the strobe asserted, -1 if not yet
  int  m_ack_at[2];     // edge dtack asserts
  int  m_idle_from[2];  // edge at which the controller returns to idle
  bit  m_rw[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_active[d]    = 1'b0;
      m_strobe_at[d] = -1;
      m_idle_from[d] = -1;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (!m_active[d]) begin
        if (edge_n > m_idle_from[d] && !AS_L && CanBusSelect_H) begin
          m_active[d]    = 1'b1;
          m_strobe_at[d] = -1;
          m_earliest[d]  = edge_n + p_setup[d] + 1;
        end
      end else if (AS_L) begin
        // End of access (normal or abort): recovery, then one idle edge.
        m_active[d]    = 1'b0;
        m_idle_from[d] = edge_n + p_rec[d] + 1;
      end else if (m_strobe_at[d] < 0) begin
        if (edge_n >= m_earliest[d] && (!UDS_L || !LDS_L)) begin
          m_strobe_at[d] = edge_n;
          m_rw[d]        = RW;
          m_ack_at[d]    = edge_n + p_strb[d] + 1;
        end
      end
    end
  endtask

  function automatic logic [4:0] model_out(input int d);
    logic strobing;
    if (!m_active[d])
      return {4'b1111, (edge_n < m_idle_from[d])};
    strobing = (m_strobe_at[d] >= 0);
    return {1'b0, !(strobing && m_rw[d]), !(strobing && !m_rw[d]),
            !(strobing && edge_n >= m_ack_at[d]), 1'b1};
  endfunction

  // Edge of the most recent 1->0 transition per output, for latency checks.
  int         fall_edge[2][5];
  logic [4:0] prev_out[2];

  task automatic clear_marks();
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < 5; b++) fall_edge[d][b] = -1;
  endtask

  task automatic step();
    logic [4:0] got;
    @(posedge Clock);
    edge_n++;
    model_edge();
    #1;
    for (int d = 0; d < 2; d++) begin
      got = get_out(d);
      check(d == 0 ? "out_def" : "out_zero", {27'd0, got}, {27'd0, model_out(d)});
      for (int b = 0; b < 5; b++)
        if (prev_out[d][b] && !got[b]) fall_edge[d][b] = edge_n;
      prev_out[d] = got;
    end
  endtask

  // Bit indices into the output bundle.
  localparam int B_CS = 4, B_RD = 3, B_WR = 2, B_DK = 1, B_BUSY = 0;

  task automatic wait_fall(input int d, input int b, input string tag);
    for (int i = 0; i < 30; i++) begin
      if (fall_edge[d][b] >= 0) break;
      step();
    end
    check(tag, {31'd0, fall_edge[d][b] >= 0}, 32'd1);
  endtask

  task automatic go_idle(input int n);
    AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  int e0, x, ds_edge;
  int hold, ds_delay, gap;

  initial begin
    Reset_L = 1'b0; AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
    RW = 1'b1; CanBusSelect_H = 1'b0;
    model_reset();
    clear_marks();
    prev_out[0] = QUIET; prev_out[1] = QUIET;

    #12;
    check("reset_def",  {27'd0, get_out(0)}, {27'd0, QUIET});
    check("reset_zero", {27'd0, get_out(1)}, {27'd0, QUIET});
    @(negedge Clock);
    Reset_L = 1'b1;
    go_idle(2);

    // Default read with data strobes already active.
    clear_marks();
    AS_L = 1'b0; CanBusSelect_H = 1'b1; UDS_L = 1'b0; LDS_L = 1'b0; RW = 1'b1;
    step();
    e0 = edge_n;
    wait_fall(0, B_DK, "rd_dtack_seen");
    check("rd_cs_at_e0",   fall_edge[0][B_CS], e0);
    check("rd_strobe_lat", fall_edge[0][B_RD] - e0, DEF_SETUP + 1);
    check("rd_dtack_lat",  fall_edge[0][B_DK] - e0, DEF_SETUP + DEF_STRB + 2);
    check("rd_no_wr",      fall_edge[0][B_WR], -1);
    check("z_strobe_lat",  fall_edge[1][B_RD] - e0, 1);
    check("z_dtack_lat",   fall_edge[1][B_DK] - e0, 2);
    AS_L = 1'b1;
    step();
    x = edge_n;
    for (int i = 0; i < 4; i++) step();
    check("rd_idle_lat", fall_edge[0][B_BUSY] - x, DEF_REC + 1);
    check("z_idle_lat",  fall_edge[1][B_BUSY] - x, 1);

    // Back-to-back: new select held during recovery. IDLE needs its own
    // sampling edge, so the next start lands one edge after recovery ends.
    clear_marks();
    AS_L = 1'b0;
    step();
    wait_fall(0, B_DK, "b2b_first_dtack");
    clear_marks();
    AS_L = 1'b1;
    step();
    x = edge_n;
    AS_L = 1'b0;
    wait_fall(0, B_CS, "b2b_second_cs");
    check("b2b_restart", fall_edge[0][B_CS] - x, DEF_REC + 2);
    go_idle(6);

    // Write with late data strobe; RW flips after the latch point.
    clear_marks();
    AS_L = 1'b0; CanBusSelect_H = 1'b1; RW = 1'b0;
    step();
    e0 = edge_n;
    for (int i = 0; i < 3; i++) step();
    UDS_L = 1'b0;
    step();
    ds_edge = edge_n;
    RW = 1'b1;
    wait_fall(0, B_DK, "wr_dtack_seen");
    check("wr_strobe_at_ds", fall_edge[0][B_WR], ds_edge);
    check("wr_dtack_lat",    fall_edge[0][B_DK] - fall_edge[0][B_WR], DEF_STRB + 1);
    check("wr_no_rd",        fall_edge[0][B_RD], -1);
    go_idle(6);

    // Abort while strobing: no dtack from the default instance.
    clear_marks();
    AS_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0; RW = 1'b1;
    wait_fall(0, B_RD, "abort_strobe_seen");
    step();
    AS_L = 1'b1;
    step();
    x = edge_n;
    for (int i = 0; i < 5; i++) step();
    check("abort_no_dtack", fall_edge[0][B_DK], -1);
    check("abort_idle_lat", fall_edge[0][B_BUSY] - x, DEF_REC + 1);

    // Asynchronous reset during ACK, then immediate restart.
    clear_marks();
    AS_L = 1'b0;
    wait_fall(0, B_DK, "rst_dtack_seen");
    #2 Reset_L = 1'b0;
    #1;
    check("async_rst_def",  {27'd0, get_out(0)}, {27'd0, QUIET});
    check("async_rst_zero", {27'd0, get_out(1)}, {27'd0, QUIET});
    model_reset();
    prev_out[0] = QUIET; prev_out[1] = QUIET;
    clear_marks();
    #2 Reset_L = 1'b1;
    step();
    check("rst_restart", fall_edge[0][B_CS], edge_n);
    go_idle(6);

    // Randomised 68k-like accesses, some aborted, some deselected.
    for (int t = 0; t < 250; t++) begin
      gap = $urandom_range(0, 3);
      for (int i = 0; i < gap; i++) begin
        AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
        CanBusSelect_H = $urandom_range(0, 1);
        RW = $urandom_range(0, 1);
        step();
      end
      AS_L = 1'b0;
      CanBusSelect_H = ($urandom_range(0, 4) != 0);
      RW = $urandom_range(0, 1);
      ds_delay = $urandom_range(0, 5);
      hold = $urandom_range(1, 14);
      for (int k = 0; k < hold; k++) begin
        if (k >= ds_delay) begin
          case ($urandom_range(0, 2))
            0: begin UDS_L = 1'b0; LDS_L = 1'b1; end
            1: begin UDS_L = 1'b1; LDS_L = 1'b0; end
            default: begin UDS_L = 1'b0; LDS_L = 1'b0; end
          endcase
        end
        if ($urandom_range(0, 7) == 0) RW = ~RW;
        if ($urandom_range(0, 7) == 0) CanBusSelect_H = ~CanBusSelect_H;
        step();
      end
      AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
      step();
    end
    go_idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
